// File: rtl/mix_columns.sv
// mix_columns: byte-serial AES MixColumns.
// One column byte enters per clock (row order 0..3). Four row accumulators
// fold in GFmul(M[r][p], in_byte); when the 4th byte (p==3) lands, the four
// row results are loaded into an output shift register and streamed out
// row 0..3 on the following four cycles.
//
// Ports:
//   clock     - single clock, rising edge
//   reset     - synchronous, active-high
//   in_byte   - column byte, one per cycle
//   enable    - per-bit accumulator keep mask (00 = first byte of a column)
//   inverse   - (only with MIXCOLUMNS_INV_EN) selects InvMixColumns matrix
//   out_byte  - registered result byte
//   out_valid - high while out_byte carries a result row
//
// Build option: define MIXCOLUMNS_INV_EN to add the inverse port.

// Per-row accumulator lane.
module mix_columns_row (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic [7:0] enable,
  input  logic [7:0] coef,
  output logic [7:0] acc_nxt
);
  logic [7:0] acc;

  // GF(2^8) multiply, polynomial 0x11B (shift-and-add with xtime).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, r;
    x = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  // enable is applied bitwise; 00 restarts, FF keeps the running sum.
  assign acc_nxt = (acc & enable) ^ gf_mul(coef, in_byte);

  always_ff @(posedge clock) begin
    if (reset) acc <= 8'h00;
    else       acc <= acc_nxt;
  end
endmodule

module mix_columns (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic [7:0] enable,
`ifdef MIXCOLUMNS_INV_EN
  input  logic       inverse,
`endif
  output logic [7:0] out_byte,
  output logic       out_valid
);
  localparam int NUM_LANES = 4;

  // Row 0 coefficients; row r is row 0 rotated right by r, so
  // M[r][p] = ROW0[(p - r) mod 4].
  localparam logic [NUM_LANES-1:0][7:0] FWD_ROW0 = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam logic [NUM_LANES-1:0][7:0] INV_ROW0 = {8'h09, 8'h0D, 8'h0B, 8'h0E};

  logic [NUM_LANES-1:0][7:0] base;
  logic [NUM_LANES-1:0][7:0] acc_nxt;
  logic [NUM_LANES-1:0][7:0] out_sr;
  logic [NUM_LANES-1:0]      vld_pipe;
  logic [1:0]                pos, p;

`ifdef MIXCOLUMNS_INV_EN
  assign base = inverse ? INV_ROW0 : FWD_ROW0;
`else
  assign base = FWD_ROW0;
`endif

  // A zero mask marks byte 0; anything else advances the position.
  assign p = (enable == 8'h00) ? 2'd0 : pos + 2'd1;

  for (genvar r = 0; r < NUM_LANES; r++) begin : g_row
    logic [1:0] sel;
    assign sel = p - 2'(r);
    mix_columns_row u_row (
      .clock   (clock),
      .reset   (reset),
      .in_byte (in_byte),
      .enable  (enable),
      .coef    (base[sel]),
      .acc_nxt (acc_nxt[r])
    );
  end

  // vld_pipe[i] marks that out_sr[i] still holds an unsent row; shifting
  // the data only while a later row is pending leaves row 3 parked on
  // out_byte once the stream ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos      <= 2'd0;
      vld_pipe <= '0;
      out_sr   <= '0;
    end else begin
      pos <= p;
      if (p == 2'd3) begin
        out_sr   <= acc_nxt;
        vld_pipe <= '1;
      end else begin
        vld_pipe <= {1'b0, vld_pipe[NUM_LANES-1:1]};
        if (vld_pipe[1]) out_sr <= {8'h00, out_sr[NUM_LANES-1:1]};
      end
    end
  end

  assign out_byte  = out_sr[0];
  assign out_valid = vld_pipe[0];
endmodule

// File: tb/tb_mix_columns.sv
// Bench for mix_columns: a column-level reference model (matrix tables,
// integer GF multiply, output queue) compared every cycle, plus literal
// expected sequences for the known AES column vectors.
module tb_mix_columns;
  typedef logic [7:0] bq_t[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_byte = 8'h00;
  logic [7:0] enable = 8'h00;
  logic       inverse = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mix_columns dut (
    .clock     (clock),
    .reset     (reset),
    .in_byte   (in_byte),
    .enable    (enable),
`ifdef MIXCOLUMNS_INV_EN
    .inverse   (inverse),
`endif
    .out_byte  (out_byte),
    .out_valid (out_valid)
  );

  int fwd [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
  int inv [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};

  function automatic int gmul(int a, int b);
    int r = 0;
    while (b != 0) begin
      if ((b & 1) != 0) r = r ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11B;
      b = b >> 1;
    end
    return r;
  endfunction

  // Reference model state
  int  m_acc [4];
  int  m_pos = 0;
  int  pend[$];
  int  exp_byte = 0;
  bit  exp_valid = 0;
  bit  started = 0;
  bq_t got_q;

  always @(posedge clock) begin
    int p;
    started = 1;
    if (reset) begin
      for (int r = 0; r < 4; r++) m_acc[r] = 0;
      m_pos = 0;
      pend.delete();
      exp_byte = 0;
      exp_valid = 0;
    end else begin
      p = (enable == 8'h00) ? 0 : (m_pos + 1) % 4;
      for (int r = 0; r < 4; r++)
        m_acc[r] = (m_acc[r] & int'(enable)) ^
                   gmul(inverse ? inv[r][p] : fwd[r][p], int'(in_byte));
      m_pos = p;
      if (p == 3) begin
        exp_byte = m_acc[0];
        exp_valid = 1;
        pend.delete();
        pend.push_back(m_acc[1]);
        pend.push_back(m_acc[2]);
        pend.push_back(m_acc[3]);
      end else if (pend.size() > 0) begin
        exp_byte = pend.pop_front();
        exp_valid = 1;
      end else begin
        exp_valid = 0;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("out_byte", int'(out_byte), exp_byte);
      if (out_valid) got_q.push_back(out_byte);
    end
  end

  task automatic chk_seq(string name, bq_t exp);
    vectors++;
    if (got_q.size() != exp.size()) begin
      miscompares++;
      $display("FAIL %s length: got %0d expected %0d", name, got_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) chk(name, int'(got_q[i]), int'(exp[i]));
    end
  endtask

  task automatic step(logic [7:0] b, logic [7:0] e);
    in_byte = b;
    enable = e;
    @(posedge clock);
    #1;
  endtask

  task automatic column(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    step(b0, 8'h00);
    step(b1, 8'hFF);
    step(b2, 8'hFF);
    step(b3, 8'hFF);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(8'h00, 8'h00);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset out_byte", int'(out_byte), 0);
    chk("reset out_valid", int'(out_valid), 0);

    // Single column
    got_q.delete();
    column(8'hAC, 8'hC1, 8'hD6, 8'hB8);
    idle(5);
    chk_seq("col1", '{8'h75, 8'hEC, 8'h09, 8'h93});
    chk("idle hold byte", int'(out_byte), 'h93);
    chk("idle valid", int'(out_valid), 0);

    // Back-to-back columns
    got_q.delete();
    column(8'hDB, 8'h13, 8'h53, 8'h45);
    column(8'hF2, 8'h0A, 8'h22, 8'h5C);
    idle(5);
    chk_seq("b2b", '{8'h8E, 8'h4D, 8'hA1, 8'hBC, 8'h9F, 8'hDC, 8'h58, 8'h9D});

    // Partial column discarded
    got_q.delete();
    step(8'hAC, 8'h00);
    step(8'hC1, 8'hFF);
    column(8'hDB, 8'h13, 8'h53, 8'h45);
    idle(5);
    chk_seq("partial", '{8'h8E, 8'h4D, 8'hA1, 8'hBC});

    // Reset during output streaming
    column(8'hDB, 8'h13, 8'h53, 8'h45);
    step(8'h00, 8'h00);
    reset = 1'b1;
    step(8'h00, 8'h00);
    reset = 1'b0;
    chk("midreset out_byte", int'(out_byte), 0);
    chk("midreset out_valid", int'(out_valid), 0);
    got_q.delete();
    column(8'hF2, 8'h0A, 8'h22, 8'h5C);
    idle(5);
    chk_seq("after reset", '{8'h9F, 8'hDC, 8'h58, 8'h9D});

`ifdef MIXCOLUMNS_INV_EN
    got_q.delete();
    inverse = 1'b1;
    column(8'h8E, 8'h4D, 8'hA1, 8'hBC);
    inverse = 1'b0;
    idle(5);
    chk_seq("inverse", '{8'hDB, 8'h13, 8'h53, 8'h45});
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      int sel;
      logic [7:0] e;
      sel = $urandom_range(0, 9);
      if (sel < 2)      e = 8'h00;
      else if (sel < 8) e = 8'hFF;
      else              e = 8'($urandom);
      reset = ($urandom_range(0, 99) == 0);
`ifdef MIXCOLUMNS_INV_EN
      inverse = ($urandom_range(0, 3) == 0);
`endif
      step(8'($urandom), e);
    end
    reset = 1'b0;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
